// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - load/store front end with read-modify-write for a 64-bit doubleword RAM
module mem_access_ctrl #(
  parameter int MEMORY_WORDS = 8064
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [15:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_error,
  output logic [12:0] ram_address,
  output logic        ram_write,
  output logic [63:0] ram_in,
  input  logic [63:0] ram_out
);

  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_DATA, WRITE, RESP} state_t;

  localparam logic [13:0] WORD_LIMIT = 14'(MEMORY_WORDS);

  state_t      state;
  logic        op_write;
  logic [1:0]  op_size;
  logic        op_signed;
  logic [2:0]  op_offset;
  logic [63:0] op_wdata;

  logic        misaligned;
  logic        out_of_range;
  logic [5:0]  lane_shift;
  logic [63:0] lane;
  logic [63:0] load_val;
  logic [63:0] merged_val;

  function automatic logic [63:0] size_mask(input logic [1:0] size);
    case (size)
      2'd0:    return 64'h0000_0000_0000_00FF;
      2'd1:    return 64'h0000_0000_0000_FFFF;
      2'd2:    return 64'h0000_0000_FFFF_FFFF;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      2'd1:    misaligned = req_addr[0];
      2'd2:    misaligned = |req_addr[1:0];
      2'd3:    misaligned = |req_addr[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  assign out_of_range = {1'b0, req_addr[15:3]} >= WORD_LIMIT;
  assign lane_shift   = {op_offset, 3'b000};

  // Lane extraction and merge both work on ram_out, which is only meaningful in RD_DATA.
  always_comb begin
    lane     = (ram_out >> lane_shift) & size_mask(op_size);
    load_val = lane;
    if (op_signed) begin
      case (op_size)
        2'd0:    if (lane[7])  load_val = lane | 64'hFFFF_FFFF_FFFF_FF00;
        2'd1:    if (lane[15]) load_val = lane | 64'hFFFF_FFFF_FFFF_0000;
        2'd2:    if (lane[31]) load_val = lane | 64'hFFFF_FFFF_0000_0000;
        default: load_val = lane;
      endcase
    end
    merged_val = (ram_out & ~(size_mask(op_size) << lane_shift))
               | ((op_wdata & size_mask(op_size)) << lane_shift);
  end

  // ram_write and resp_valid are flops set on entry to WRITE/RESP, so they cannot glitch.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_rdata  <= 64'd0;
      resp_error  <= 1'b0;
      ram_address <= 13'd0;
      ram_write   <= 1'b0;
      ram_in      <= 64'd0;
      op_write    <= 1'b0;
      op_size     <= 2'd0;
      op_signed   <= 1'b0;
      op_offset   <= 3'd0;
      op_wdata    <= 64'd0;
    end else begin
      ram_write  <= 1'b0;
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_write  <= req_write;
            op_size   <= req_size;
            op_signed <= req_signed;
            op_offset <= req_addr[2:0];
            op_wdata  <= req_wdata;
            req_ready <= 1'b0;
            if (misaligned || out_of_range) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_rdata <= 64'd0;
            end else if (req_write && req_size == 2'd3) begin
              state       <= WRITE;
              ram_address <= req_addr[15:3];
              ram_in      <= req_wdata;
              ram_write   <= 1'b1;
            end else begin
              state       <= RD_ISSUE;
              ram_address <= req_addr[15:3];
            end
          end
        end
        RD_ISSUE: state <= RD_DATA;
        RD_DATA: begin
          if (op_write) begin
            state     <= WRITE;
            ram_in    <= merged_val;
            ram_write <= 1'b1;
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_error <= 1'b0;
            resp_rdata <= load_val;
          end
        end
        WRITE: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_error <= 1'b0;
          resp_rdata <= 64'd0;
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - randomized self-checking bench for mem_access_ctrl against a byte-level memory model
module tb_mem_access_ctrl;

  localparam int WORDS = 8064;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [15:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_error;
  logic [12:0] ram_address;
  logic        ram_write;
  logic [63:0] ram_in;
  logic [63:0] ram_out;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  mem_access_ctrl #(.MEMORY_WORDS(WORDS)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_error(resp_error), .ram_address(ram_address), .ram_write(ram_write),
    .ram_in(ram_in), .ram_out(ram_out)
  );

  function automatic logic [63:0] pattern(input int w);
    logic [31:0] a, b;
    a = 32'(w) * 32'h9E37_79B1;
    b = (32'(w) ^ 32'h5A5A_5A5A) * 32'h85EB_CA77;
    return {a, b};
  endfunction

  // RAM: synchronous read, write-first; unwritten words read a fixed per-word pattern.
  logic [63:0] ram [8192];
  bit          written [8192];
  always @(posedge clock) begin
    if (ram_write) begin
      ram[ram_address]     <= ram_in;
      written[ram_address] <= 1'b1;
      ram_out              <= ram_in;
    end else begin
      ram_out <= written[ram_address] ? ram[ram_address] : pattern(int'(ram_address));
    end
  end

  int          wr_count = 0;
  logic [12:0] wr_addr;
  logic [63:0] wr_data;
  always @(posedge clock) begin
    if (ram_write) begin
      wr_count <= wr_count + 1;
      wr_addr  <= ram_address;
      wr_data  <= ram_in;
    end
  end

  // Reference memory as individual bytes.
  logic [7:0] mem_b [int];

  function automatic logic [7:0] ref_byte(input int a);
    logic [63:0] p;
    if (mem_b.exists(a)) return mem_b[a];
    p = pattern(a / 8);
    return p[8*(a%8) +: 8];
  endfunction

  function automatic logic [63:0] ref_load(input int a, input int sz, input bit sg);
    int n;
    logic [63:0] v;
    n = 1 << sz;
    v = 64'd0;
    for (int i = 0; i < n; i++) v = v | (64'(ref_byte(a + i)) << (8 * i));
    if (sg && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8 * n));
    return v;
  endfunction

  task automatic ref_store(input int a, input int sz, input logic [63:0] wd);
    for (int i = 0; i < (1 << sz); i++) mem_b[a + i] = wd[8*i +: 8];
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_req(input bit wr, input int sz, input bit sg, input int a, input logic [63:0] wd);
    bit          err;
    int          exp_lat, lat, w0;
    logic [63:0] exp_rd;
    err = ((a % (1 << sz)) != 0) || ((a / 8) >= WORDS);
    exp_rd = 64'd0;
    if (!err && !wr) exp_rd = ref_load(a, sz, sg);
    if (err) exp_lat = 1;
    else if (!wr) exp_lat = 3;
    else if (sz == 3) exp_lat = 2;
    else exp_lat = 4;

    @(negedge clock);
    check("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid  = 1'b1;
    req_write  = wr;
    req_size   = 2'(sz);
    req_signed = sg;
    req_addr   = 16'(a);
    req_wdata  = wd;
    w0 = wr_count;
    @(posedge clock);
    #1 req_valid = 1'b0;
    req_wdata = $urandom;
    lat = 0;
    for (int c = 1; c <= 8; c++) begin
      if (resp_valid) begin
        lat = c;
        break;
      end
      @(posedge clock);
      #1;
    end
    check("resp_latency", 64'(lat), 64'(exp_lat));
    if (lat != 0) begin
      check("resp_error", 64'(resp_error), 64'(err));
      check("resp_rdata", resp_rdata, exp_rd);
    end
    if (wr && !err) ref_store(a, sz, wd);
    check("ram_write_count", 64'(wr_count - w0), 64'((wr && !err) ? 1 : 0));
    if (wr && !err) begin
      check("ram_write_addr", 64'(wr_addr), 64'(a / 8));
      check("ram_write_data", wr_data, ref_load((a / 8) * 8, 3, 1'b0));
    end
    @(posedge clock);
    #1;
    check("resp_pulse_end", 64'(resp_valid), 64'd0);
    check("req_ready_back", 64'(req_ready), 64'd1);
  endtask

  task automatic reset_during_rmw(input int a, input logic [63:0] wd);
    int w0;
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 16'(a); req_wdata = wd;
    w0 = wr_count;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(posedge clock);
    #1 reset_n = 1'b0;
    #1;
    check("rst_ram_write", 64'(ram_write), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      check("rst_hold_ram_write", 64'(ram_write), 64'd0);
      check("rst_hold_resp_valid", 64'(resp_valid), 64'd0);
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check("rst_no_write", 64'(wr_count - w0), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    do_req(1'b0, 3, 1'b0, (a / 8) * 8, 64'd0);
    do_req(1'b0, 0, 1'b0, a, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, a;
    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_addr = 16'd0; req_wdata = 64'd0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_ram_write", 64'(ram_write), 64'd0);
    check("reset_resp_valid", 64'(resp_valid), 64'd0);
    check("reset_resp_error", 64'(resp_error), 64'd0);
    check("reset_resp_rdata", resp_rdata, 64'd0);
    check("reset_ram_address", 64'(ram_address), 64'd0);
    check("reset_ram_in", ram_in, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check("reset_req_ready", 64'(req_ready), 64'd1);

    do_req(1'b1, 3, 1'b0, 16'h0010, 64'h1122_3344_5566_7788);
    do_req(1'b0, 3, 1'b0, 16'h0010, 64'd0);
    do_req(1'b1, 0, 1'b0, 16'h0013, 64'h0000_0000_0000_00AB);
    do_req(1'b1, 2, 1'b0, 16'h0014, 64'h0000_0000_DEAD_BEEF);
    do_req(1'b0, 3, 1'b0, 16'h0010, 64'd0);
    do_req(1'b0, 0, 1'b1, 16'h0013, 64'd0);
    do_req(1'b0, 1, 1'b0, 16'h0016, 64'd0);
    do_req(1'b0, 1, 1'b0, 16'h0011, 64'd0);
    do_req(1'b1, 3, 1'b0, 16'h0014, 64'hFFFF_FFFF_FFFF_FFFF);
    do_req(1'b0, 3, 1'b0, 16'hFC00, 64'd0);
    do_req(1'b0, 3, 1'b0, 16'hFBF8, 64'd0);
    do_req(1'b0, 2, 1'b1, 16'hFBFC, 64'd0);
    reset_during_rmw(16'h0015, 64'h0000_0000_0000_0055);

    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      if (r < 7)      a = $urandom_range(0, 127);
      else if (r < 9) a = 8060 * 8 + $urandom_range(0, 31);
      else            a = $urandom_range(WORDS * 8, 65535);
      do_req(1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
             a, {$urandom, $urandom});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
